dbg_capture_trigger: RTL

- Trigger and qualification stage that feeds the debug capture RAM write port.
- Takes the 256-bit per-cycle AXI/FSM trace word and runs a circular pre-trigger buffer.
- Detects a masked-compare or external trigger, then records a programmable number of post-trigger samples and stops.
- Produces the capture RAM write enable, address and data, plus status words that are readable over JTAG.

---
 rtl/dbg_capture_trigger_if.sv | 21 ++
 rtl/dbg_capture_trigger.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/dbg_capture_trigger_if.sv
// ---------------------------------------------------------------------------
// dbg_capture_trigger_if
// Write port of the debug capture RAM.
//   mem_we    : write enable for this cycle
//   mem_addr  : word address to write
//   mem_wdata : trace word to store
// Modports:
//   master : the trigger stage, which drives the write port
//   slave  : the capture RAM, which receives the writes
// ---------------------------------------------------------------------------
interface dbg_capture_trigger_if #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 9
);
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  modport master (output mem_we, output mem_addr, output mem_wdata);
  modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/dbg_capture_trigger.sv
// ---------------------------------------------------------------------------
// dbg_capture_trigger
// Trigger and qualification stage in front of the debug capture RAM. Trace
// words go into a circular pre-trigger buffer. A masked compare or an
// external trigger stops the pre-trigger phase. A programmable number of
// post-trigger samples is then recorded, and the capture stops.
//
// Ports:
//   clk, rst          capture clock, synchronous active-high reset
//   arm_i, abort_i    single-cycle pulses: start / cancel a capture
//   trig_mask_i       compare mask (1 = bit participates)
//   trig_value_i      compare value
//   trig_ext_i        external trigger, qualified by sample_valid_i
//   post_count_i      samples to record after the trigger sample
//   sample_i          trace word
//   sample_valid_i    trace word is valid this cycle
//   mem               capture RAM write port (master side)
//   state_o           0=IDLE 1=PRE 2=POST 3=DONE
//   triggered_o       trigger seen in this capture
//   trig_addr_o       RAM address that holds the trigger sample
//   wrapped_o         write pointer has wrapped at least once
//   oldest_addr_o     address of the oldest valid sample
//   done_o            capture complete
// ---------------------------------------------------------------------------
module dbg_capture_trigger #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm_i,
  input  logic                  abort_i,
  input  logic [DATA_WIDTH-1:0] trig_mask_i,
  input  logic [DATA_WIDTH-1:0] trig_value_i,
  input  logic                  trig_ext_i,
  input  logic [ADDR_WIDTH-1:0] post_count_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  input  logic                  sample_valid_i,
  dbg_capture_trigger_if.master mem,
  output logic [1:0]            state_o,
  output logic                  triggered_o,
  output logic [ADDR_WIDTH-1:0] trig_addr_o,
  output logic                  wrapped_o,
  output logic [ADDR_WIDTH-1:0] oldest_addr_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_post_cnt;
  logic [ADDR_WIDTH-1:0] r_trig_addr;
  logic                  r_triggered;
  logic                  r_wrapped;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;

  logic [DATA_WIDTH-1:0] w_bit_miss;
  logic                  w_match;
  logic                  w_write;

  // Per-bit disagreement with the compare value, restricted to masked-in bits.
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_cmp
    assign w_bit_miss[gi] = (sample_i[gi] ^ trig_value_i[gi]) & trig_mask_i[gi];
  end

  assign w_match = sample_valid_i & ((~|w_bit_miss) | trig_ext_i);

  // A sample that arrives in the same cycle as abort is dropped.
  assign w_write = sample_valid_i & ~abort_i &
                   ((r_state == ST_PRE) | (r_state == ST_POST));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_post_cnt  <= '0;
      r_trig_addr <= '0;
      r_triggered <= 1'b0;
      r_wrapped   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_we <= 1'b0;

      if (w_write) begin
        r_mem_we    <= 1'b1;
        r_mem_addr  <= r_wr_ptr;
        r_mem_wdata <= sample_i;
        r_wr_ptr    <= r_wr_ptr + ADDR_WIDTH'(1);
        // All-ones is DEPTH-1 for any address width.
        if (r_wr_ptr == '1) begin
          r_wrapped <= 1'b1;
        end
      end

      if (abort_i) begin
        // Status and pointer are kept so they stay readable after a cancel.
        r_state <= ST_IDLE;
      end else begin
        unique case (r_state)
          ST_IDLE, ST_DONE: begin
            if (arm_i) begin
              r_state     <= ST_PRE;
              r_wr_ptr    <= '0;
              r_triggered <= 1'b0;
              r_wrapped   <= 1'b0;
              r_trig_addr <= '0;
            end
          end
          ST_PRE: begin
            if (w_match) begin
              r_trig_addr <= r_wr_ptr;
              r_triggered <= 1'b1;
              r_post_cnt  <= post_count_i;
              r_state     <= (post_count_i == '0) ? ST_DONE : ST_POST;
            end
          end
          ST_POST: begin
            if (sample_valid_i) begin
              r_post_cnt <= r_post_cnt - ADDR_WIDTH'(1);
              if (r_post_cnt == ADDR_WIDTH'(1)) begin
                r_state <= ST_DONE;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;

  assign state_o       = r_state;
  assign triggered_o   = r_triggered;
  assign trig_addr_o   = r_trig_addr;
  assign wrapped_o     = r_wrapped;
  // Before the first wrap the buffer fills from address 0 upward.
  assign oldest_addr_o = r_wrapped ? r_wr_ptr : '0;
  assign done_o        = (r_state == ST_DONE);

endmodule
